regfile_mp: RTL

- Parametrised multi-read-port register file, successor to the single-issue MIPS register file.
- Adds configurable width, depth and read-port count, plus a sequential post-reset initialisation walk.
- Adds a pending-write scoreboard for load-use hazard detection and a write-to-read bypass.
- Sits in the decode stage: read ports feed the ID/EX operands; the write port is driven from writeback; the lock port is driven from issue.

---
 rtl/regfile_mp_pkg.sv | 34 +++
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_mp_scoreboard.sv | 50 +++++
 rtl/regfile_mp.sv | 103 ++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared types, default sizes and port-slice helpers for the multi-port register file.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

    localparam int REGFILE_DATA_W = 32;
    localparam int REGFILE_ADDR_W = 5;
    localparam int REGFILE_NUM_RD = 2;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Helpers work on generously wide containers so one function serves every port width
    localparam int PACK_MAX  = 1024;
    localparam int SLICE_MAX = 256;

    typedef logic [PACK_MAX-1:0]  pack_t;
    typedef logic [SLICE_MAX-1:0] slice_t;

    function automatic slice_t port_get(input pack_t vec, input int idx, input int w);
        pack_t mask;
        mask = (pack_t'(1) << w) - pack_t'(1);
        return slice_t'((vec >> (idx * w)) & mask);
    endfunction

    function automatic pack_t port_put(input pack_t vec, input int idx, input int w,
                                       input slice_t val);
        pack_t mask;
        mask = ((pack_t'(1) << w) - pack_t'(1)) << (idx * w);
        return (vec & ~mask) | ((pack_t'(val) << (idx * w)) & mask);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode-stage bus of the register file: read ports, writeback write port and issue lock port.
// The same bus carries bypassed data when REGFILE_BYPASS_EN is defined.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W,
    parameter int NUM_RD = REGFILE_NUM_RD
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pend;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     lock_en;
    logic [ADDR_W-1:0]        lock_addr;
    logic                     init_busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, lock_en, lock_addr,
        input  rd_data, rd_pend, init_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, lock_en, lock_addr,
        output rd_data, rd_pend, init_busy
    );

endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write bits for load-use hazard detection: lock sets, writeback clears, lock wins.
// Register 0 is never pending when ZERO_REG is set.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = REGFILE_ADDR_W,
    parameter int NUM_RD   = REGFILE_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     clr_en,
    input  logic [ADDR_W-1:0]        clr_addr,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_pend
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0] pend;
    logic                clr_ok;
    logic                set_ok;
    logic [ADDR_W-1:0]   lookup_addr;

    assign clr_ok = clr_en && !(ZERO_REG != 0 && clr_addr == '0);
    assign set_ok = set_en && !(ZERO_REG != 0 && set_addr == '0);

    // Set is applied after clear so a same-cycle lock keeps the register pending
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
        end else if (run) begin
            if (clr_ok) pend[clr_addr] <= 1'b0;
            if (set_ok) pend[set_addr] <= 1'b1;
        end
    end

    always_comb begin
        rd_pend     = '0;
        lookup_addr = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            lookup_addr = ADDR_W'(port_get(pack_t'(rd_addr), i, ADDR_W));
            rd_pend[i]  = run && pend[lookup_addr] &&
                          !(ZERO_REG != 0 && lookup_addr == '0);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with post-reset init walk and pending scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data onto matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REGFILE_DATA_W,
    parameter int ADDR_W   = REGFILE_ADDR_W,
    parameter int NUM_RD   = REGFILE_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [0:0]      ST_INIT  = 1'(INIT);
    localparam logic [0:0]      ST_RUN   = 1'(RUN);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_REGS - 1);

    logic [0:0]        state;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] mem [NUM_REGS];
    logic              run;
    logic              wr_ok;
    logic [NUM_RD-1:0] sb_pend;

    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [NUM_RD-1:0]        rd_pend_c;
    logic [ADDR_W-1:0]        port_addr;
    logic [DATA_W-1:0]        port_data;
    logic                     port_pend;

    assign run   = (state == ST_RUN);
    assign wr_ok = run && bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == '0);

    // The walk visits every entry once; cnt then parks at NUM_REGS until the next reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + (ADDR_W+1)'(1);
            if (cnt == LAST_IDX) state <= ST_RUN;
        end
    end

    // Storage has no reset; the init walk gives every entry a known value instead
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == ST_INIT) begin
                mem[cnt[ADDR_W-1:0]] <= DATA_W'(cnt);
            end else if (wr_ok) begin
                mem[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .clr_en   (bus.wr_en),
        .clr_addr (bus.wr_addr),
        .set_en   (bus.lock_en),
        .set_addr (bus.lock_addr),
        .rd_addr  (bus.rd_addr),
        .rd_pend  (sb_pend)
    );

    always_comb begin
        rd_data_c = '0;
        rd_pend_c = '0;
        port_addr = '0;
        port_data = '0;
        port_pend = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            port_addr = ADDR_W'(port_get(pack_t'(bus.rd_addr), i, ADDR_W));
            port_data = '0;
            if (run && !(ZERO_REG != 0 && port_addr == '0)) port_data = mem[port_addr];
            port_pend = sb_pend[i];
`ifdef REGFILE_BYPASS_EN
            // Write-first: the register stays pending only if it is re-locked this cycle
            if (wr_ok && bus.wr_addr == port_addr) begin
                port_data = bus.wr_data;
                port_pend = bus.lock_en && (bus.lock_addr == bus.wr_addr);
            end
`endif
            rd_data_c    = (NUM_RD*DATA_W)'(port_put(pack_t'(rd_data_c), i, DATA_W,
                                                     slice_t'(port_data)));
            rd_pend_c[i] = port_pend;
        end
    end

    assign bus.rd_data   = rd_data_c;
    assign bus.rd_pend   = rd_pend_c;
    assign bus.init_busy = !run;

endmodule
